misao_flow_ctrl: RTL and testbench

// Parametrised program-flow unit for the MISA-O core. Owns the nibble-granular PC, resolves

---
 rtl/misao_flow_ctrl.sv | 138 +++++++++++++
 tb/tb_misao_flow_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/misao_flow_ctrl.sv
// misao_flow_ctrl: MISA-O program counter, relative/absolute branch resolution and return-address stack
module misao_flow_ctrl #(
  parameter int PC_W      = 16,
  parameter int OFF_W     = 8,
  parameter int BRS_SHIFT = 2,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         op_start,
  input  logic [1:0]                   adv,
  input  logic                         br_req,
  input  logic [2:0]                   br_op,
  input  logic [OFF_W-1:0]             br_off,
  input  logic                         br_w8,
  input  logic                         br_brs,
  input  logic                         flag_z,
  input  logic                         flag_c,
  input  logic [PC_W-1:0]              jmp_target,
  input  logic                         ras_clr,
  output logic [PC_W-1:0]              pc,
  output logic [PC_W-2:0]              mem_addr,
  output logic                         flush,
  output logic                         link_we,
  output logic [PC_W-1:0]              link_val,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf
);
  localparam int AW = $clog2(RAS_DEPTH);
  typedef enum logic {IDLE, REDIR} st_t;
  st_t st_q, st_d;
  logic [PC_W-1:0] pc_q, pc_d, base_q, base_d, link_q, link_d;
  logic [PC_W-1:0] seq, rel, off, sx, base_e, top;
  logic [OFF_W-1:0] raw;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0] cnt_q, cnt_d, cnt_e;
  logic ovf_q, ovf_d, unf_q, unf_d, lwe_q, lwe_d, taken, full;
  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [PC_W-1:0] ras_d [RAS_DEPTH];
  assign pc        = pc_q;
  assign mem_addr  = pc_q[PC_W-1:1];
  assign flush     = st_q == REDIR;
  assign link_we   = lwe_q;
  assign link_val  = link_q;
  assign ras_count = cnt_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
  // Address arithmetic: sequential next pc, scaled relative target, effective RAS view after clear
  always_comb begin
    raw    = br_w8 ? br_off : {{(OFF_W-4){br_off[3]}}, br_off[3:0]};
    sx     = {{(PC_W-OFF_W){raw[OFF_W-1]}}, raw};
    off    = br_brs ? sx << (BRS_SHIFT + 1) : sx << 1;
    base_e = op_start ? pc_q : base_q;
    rel    = base_e + off;
    seq    = pc_q + PC_W'(adv);
    cnt_e  = ras_clr ? '0 : cnt_q;
    full   = cnt_e == (AW+1)'(RAS_DEPTH);
    top    = ras_q[ptr_q - AW'(1)];
  end
  // Next-state: flow-control decode, RAS push/pop and redirect FSM
  always_comb begin
    pc_d   = pc_q;
    base_d = base_q;
    link_d = link_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    ras_d  = ras_q;
    lwe_d  = 1'b0;
    taken  = 1'b0;
    st_d   = IDLE;
    if (!stall) begin
      base_d = base_e;
      cnt_d  = cnt_e;
      ovf_d  = ovf_q & ~ras_clr;
      unf_d  = unf_q & ~ras_clr;
      pc_d   = seq;
      if (br_req) begin
        case (br_op)
          3'd0: begin taken = flag_z; pc_d = flag_z ? rel : seq; end
          3'd1: begin taken = flag_c; pc_d = flag_c ? rel : seq; end
          3'd2: begin taken = 1'b1; pc_d = jmp_target; end
          3'd3: begin
            taken = 1'b1;
            pc_d  = jmp_target;
            link_d = seq;
            lwe_d = 1'b1;
            ras_d[ptr_q] = seq;
            ptr_d = ptr_q + AW'(1);
            cnt_d = full ? cnt_e : cnt_e + (AW+1)'(1);
            ovf_d = ovf_d | full;
          end
          3'd4: begin
            taken = 1'b1;
            pc_d  = (cnt_e != '0) ? top : jmp_target;
            ptr_d = (cnt_e != '0) ? ptr_q - AW'(1) : ptr_q;
            cnt_d = (cnt_e != '0) ? cnt_e - (AW+1)'(1) : cnt_e;
            unf_d = unf_d | (cnt_e == '0);
          end
          default: pc_d = seq;
        endcase
      end
      st_d = taken ? REDIR : IDLE;
    end
  end
  // Control and address state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= PC_W'(RESET_PC);
      base_q <= PC_W'(RESET_PC);
      link_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      lwe_q  <= 1'b0;
      st_q   <= IDLE;
    end else begin
      pc_q   <= pc_d;
      base_q <= base_d;
      link_q <= link_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      lwe_q  <= lwe_d;
      st_q   <= st_d;
    end
  end
  // Return-address storage; contents need no reset since ras_count gates validity
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end
endmodule

// File: tb/tb_misao_flow_ctrl.sv
// tb_misao_flow_ctrl: vector table plus reset/async corner sequences, scoreboard-checked
module tb_misao_flow_ctrl;
  logic clk = 1'b0, rst = 1'b1, stall = 0, op_start = 0, br_req = 0, br_w8 = 0, br_brs = 0;
  logic flag_z = 0, flag_c = 0, ras_clr = 0;
  logic [1:0] adv = 0;
  logic [2:0] br_op = 0;
  logic [7:0] br_off = 0;
  logic [15:0] jmp_target = 0;
  logic [15:0] pc, link_val;
  logic [14:0] mem_addr;
  logic flush, link_we, ras_ovf, ras_unf;
  logic [2:0] ras_count;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic stall, op_start; logic [1:0] adv; logic br_req; logic [2:0] op; logic [7:0] off;
    logic w8, brs, z, c; logic [15:0] jt; logic clr;
    logic [15:0] pc; logic fl, lwe; logic [15:0] lv; logic [2:0] cnt; logic ovf, unf;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];

  misao_flow_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .op_start(op_start), .adv(adv), .br_req(br_req),
    .br_op(br_op), .br_off(br_off), .br_w8(br_w8), .br_brs(br_brs), .flag_z(flag_z),
    .flag_c(flag_c), .jmp_target(jmp_target), .ras_clr(ras_clr), .pc(pc), .mem_addr(mem_addr),
    .flush(flush), .link_we(link_we), .link_val(link_val), .ras_count(ras_count),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic os, logic [1:0] a, logic br, logic [2:0] op,
                              logic [7:0] of, logic w8, logic brs, logic z, logic c,
                              logic [15:0] jt, logic clr, logic [15:0] epc, logic efl,
                              logic elwe, logic [15:0] elv, logic [2:0] ecnt, logic eovf,
                              logic eunf);
    vec_t v;
    v.stall = s; v.op_start = os; v.adv = a; v.br_req = br; v.op = op; v.off = of;
    v.w8 = w8; v.brs = brs; v.z = z; v.c = c; v.jt = jt; v.clr = clr;
    v.pc = epc; v.fl = efl; v.lwe = elwe; v.lv = elv; v.cnt = ecnt; v.ovf = eovf; v.unf = eunf;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_out(string tag);
    vec_t e;
    e = sb.pop_front();
    chk({tag, ".pc"}, 32'(pc), 32'(e.pc));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(e.pc[15:1]));
    chk({tag, ".flush"}, 32'(flush), 32'(e.fl));
    chk({tag, ".link_we"}, 32'(link_we), 32'(e.lwe));
    chk({tag, ".link_val"}, 32'(link_val), 32'(e.lv));
    chk({tag, ".ras_count"}, 32'(ras_count), 32'(e.cnt));
    chk({tag, ".ras_ovf"}, 32'(ras_ovf), 32'(e.ovf));
    chk({tag, ".ras_unf"}, 32'(ras_unf), 32'(e.unf));
  endtask

  task automatic drive(vec_t v);
    stall = v.stall; op_start = v.op_start; adv = v.adv; br_req = v.br_req; br_op = v.op;
    br_off = v.off; br_w8 = v.w8; br_brs = v.brs; flag_z = v.z; flag_c = v.c;
    jmp_target = v.jt; ras_clr = v.clr;
  endtask

  task automatic apply(vec_t v, string tag);
    @(negedge clk);
    drive(v);
    sb.push_back(v);
    @(posedge clk);
    #1;
    cmp_out(tag);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,8'h00,0,0,0,0,16'h0000,0, 16'h0002,0,0,16'h0000,0,0,0);
    //          s os a br op off   w8 brs z c jt      clr  pc      fl lwe lv     cnt o u
    tbl.push_back(mk(0,0,0,0,0,8'h00,0,0,0,0,16'h0000,0, 16'h0002,0,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,2,0,0,8'h00,0,0,0,0,16'h0000,0, 16'h0004,0,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,1,2,8'h00,0,0,0,0,16'h000C,0, 16'h000C,1,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,8'h02,0,0,1,0,16'h0000,0, 16'h0010,1,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00,0,0,0,0,16'h0000,0, 16'h0010,0,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,1,1,0,8'h02,0,0,0,0,16'h0000,0, 16'h0011,0,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,1,2,8'h00,0,0,0,0,16'h00AE,0, 16'h00AE,1,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,8'h0C,0,0,1,0,16'h0000,0, 16'h00A6,1,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,8'h01,0,1,1,0,16'h0000,0, 16'h00B6,1,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,1,2,8'h00,0,0,0,0,16'h0100,0, 16'h0100,1,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,1,0,1,1,8'h80,1,0,0,1,16'h0000,0, 16'h0000,1,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,2,1,1,8'h80,1,0,0,0,16'h0000,0, 16'h0002,0,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,1,1,5,8'h00,0,0,1,1,16'h0050,0, 16'h0003,0,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,1,2,8'h00,0,0,0,0,16'hFFFF,0, 16'hFFFF,1,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,2,0,0,8'h00,0,0,0,0,16'h0000,0, 16'h0001,0,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,1,2,8'h00,0,0,0,0,16'h0010,0, 16'h0010,1,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,2,1,3,8'h00,0,0,0,0,16'h0040,0, 16'h0040,1,1,16'h0012,1,0,0));
    tbl.push_back(mk(0,0,0,1,2,8'h00,0,0,0,0,16'h0020,0, 16'h0020,1,0,16'h0012,1,0,0));
    tbl.push_back(mk(0,0,2,1,3,8'h00,0,0,0,0,16'h0042,0, 16'h0042,1,1,16'h0022,2,0,0));
    tbl.push_back(mk(0,0,0,1,2,8'h00,0,0,0,0,16'h0030,0, 16'h0030,1,0,16'h0022,2,0,0));
    tbl.push_back(mk(0,0,2,1,3,8'h00,0,0,0,0,16'h0044,0, 16'h0044,1,1,16'h0032,3,0,0));
    tbl.push_back(mk(0,0,0,1,2,8'h00,0,0,0,0,16'h0040,0, 16'h0040,1,0,16'h0032,3,0,0));
    tbl.push_back(mk(0,0,2,1,3,8'h00,0,0,0,0,16'h0046,0, 16'h0046,1,1,16'h0042,4,0,0));
    tbl.push_back(mk(0,0,0,1,2,8'h00,0,0,0,0,16'h0050,0, 16'h0050,1,0,16'h0042,4,0,0));
    tbl.push_back(mk(0,0,2,1,3,8'h00,0,0,0,0,16'h0048,0, 16'h0048,1,1,16'h0052,4,1,0));
    tbl.push_back(mk(0,0,0,1,4,8'h00,0,0,0,0,16'h0077,0, 16'h0052,1,0,16'h0052,3,1,0));
    tbl.push_back(mk(0,0,0,1,4,8'h00,0,0,0,0,16'h0077,0, 16'h0042,1,0,16'h0052,2,1,0));
    tbl.push_back(mk(0,0,0,1,4,8'h00,0,0,0,0,16'h0077,0, 16'h0032,1,0,16'h0052,1,1,0));
    tbl.push_back(mk(0,0,0,1,4,8'h00,0,0,0,0,16'h0077,0, 16'h0022,1,0,16'h0052,0,1,0));
    tbl.push_back(mk(0,0,0,1,4,8'h00,0,0,0,0,16'h0077,0, 16'h0077,1,0,16'h0052,0,1,1));
    tbl.push_back(mk(1,0,2,1,2,8'h00,0,0,0,0,16'h0064,0, 16'h0077,0,0,16'h0052,0,1,1));
    tbl.push_back(mk(1,0,2,1,2,8'h00,0,0,0,0,16'h0064,0, 16'h0077,0,0,16'h0052,0,1,1));
    tbl.push_back(mk(1,0,2,1,2,8'h00,0,0,0,0,16'h0064,0, 16'h0077,0,0,16'h0052,0,1,1));
    tbl.push_back(mk(0,0,2,1,2,8'h00,0,0,0,0,16'h0064,0, 16'h0064,1,0,16'h0052,0,1,1));
    tbl.push_back(mk(0,0,2,1,3,8'h00,0,0,0,0,16'h0090,1, 16'h0090,1,1,16'h0066,1,0,0));
    tbl.push_back(mk(0,0,0,1,4,8'h00,0,0,0,0,16'h00A0,1, 16'h00A0,1,0,16'h0066,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,8'h00,0,0,0,0,16'h0000,1, 16'h00A1,0,0,16'h0066,0,0,0));

    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(idle);
    cmp_out("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    @(negedge clk);
    drive(mk(0,0,2,1,3,8'h00,0,0,0,0,16'h0055,0, 16'h0,0,0,16'h0,0,0,0));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.pc", 32'(pc), 32'h0002);
    chk("async_rst.ras_count", 32'(ras_count), 32'h0);
    @(posedge clk);
    #1;
    sb.push_back(idle);
    cmp_out("rst_mid_jal");
    rst = 1'b0;
    apply(idle, "post_rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
